// File: rtl/network_requester_if.sv
// Bundles the core request/response handshake and the router-port packet
// fields that run between a network_requester and its neighbours.
interface network_requester_if #(
  parameter int NAW  = 4,
  parameter int CBAW = 8,
  parameter int DW   = 32
);
  logic                portEnable;
  logic                reqValid;
  logic                reqReady;
  logic                reqWrite;
  logic [NAW+CBAW-1:0] reqAddress;
  logic [DW-1:0]       reqData;
  logic                respValid;
  logic [DW-1:0]       respData;
  logic                respError;
  logic [NAW+CBAW-1:0] destinationAddressOut;
  logic [NAW-1:0]      requesterAddressOut;
  logic                readOut;
  logic                writeOut;
  logic [DW-1:0]       dataOut;
  logic [NAW+CBAW-1:0] destinationAddressIn;
  logic [NAW-1:0]      requesterAddressIn;
  logic                readIn;
  logic                writeIn;
  logic [DW-1:0]       dataIn;

  // Core and mesh side that drives the requester.
  modport master (
    output portEnable, reqValid, reqWrite, reqAddress, reqData,
    output destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn,
    input  reqReady, respValid, respData, respError,
    input  destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut
  );

  modport slave (
    input  portEnable, reqValid, reqWrite, reqAddress, reqData,
    input  destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn,
    output reqReady, respValid, respData, respError,
    output destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut
  );
endinterface

// File: rtl/network_requester.sv
// Single-outstanding mesh initiator: turns core requests into router packets,
// matches the read reply, times out idle reads and counts stray replies.
module network_requester #(
  parameter int NETWORK_ADDRESS_WIDTH    = 4,
  parameter int CACHE_BANK_ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH               = 32,
  parameter int TIMEOUT_CYCLES           = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0] localRouterAddress,
  output logic [7:0]                       strayCount,
  network_requester_if.slave               bus
);
  localparam int NAW   = NETWORK_ADDRESS_WIDTH;
  localparam int AW    = NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       stray_q, stray_d;
  logic [AW-1:0]    dest_out_q, dest_out_d;
  logic [NAW-1:0]   req_out_q, req_out_d;
  logic             read_out_q, read_out_d;
  logic             write_out_q, write_out_d;
  logic [DW-1:0]    data_out_q, data_out_d;
  logic             resp_valid_q, resp_valid_d;
  logic [DW-1:0]    resp_data_q, resp_data_d;
  logic             resp_error_q, resp_error_d;
  logic             is_reply;

  // The requester field and the bank bits of an incoming packet play no part in matching.
  logic unused_in;
  assign unused_in = ^{bus.requesterAddressIn, bus.destinationAddressIn[AW-NAW-1:0]};

  assign is_reply = bus.readIn && bus.writeIn &&
                    (bus.destinationAddressIn[AW-1 -: NAW] == localRouterAddress);

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    stray_d      = stray_q;
    dest_out_d   = '0;
    req_out_d    = '0;
    read_out_d   = 1'b0;
    write_out_d  = 1'b0;
    data_out_d   = '0;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.reqValid) begin
          write_d = bus.reqWrite;
          addr_d  = bus.reqAddress;
          data_d  = bus.reqData;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.portEnable) begin
          dest_out_d  = addr_q;
          req_out_d   = localRouterAddress;
          read_out_d  = !write_q;
          write_out_d = write_q;
          data_out_d  = write_q ? data_q : '0;
          cnt_d       = '0;
          state_d     = write_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        // A reply landing on the timeout edge still completes the read cleanly.
        if (is_reply) begin
          resp_valid_d = 1'b1;
          resp_data_d  = bus.dataIn;
          state_d      = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (is_reply && state_q != WAIT && stray_q != 8'hFF)
      stray_d = stray_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      stray_q      <= '0;
      dest_out_q   <= '0;
      req_out_q    <= '0;
      read_out_q   <= 1'b0;
      write_out_q  <= 1'b0;
      data_out_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      stray_q      <= stray_d;
      dest_out_q   <= dest_out_d;
      req_out_q    <= req_out_d;
      read_out_q   <= read_out_d;
      write_out_q  <= write_out_d;
      data_out_q   <= data_out_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign bus.reqReady              = (state_q == IDLE);
  assign bus.respValid             = resp_valid_q;
  assign bus.respData              = resp_data_q;
  assign bus.respError             = resp_error_q;
  assign bus.destinationAddressOut = dest_out_q;
  assign bus.requesterAddressOut   = req_out_q;
  assign bus.readOut               = read_out_q;
  assign bus.writeOut              = write_out_q;
  assign bus.dataOut               = data_out_q;
  assign strayCount                = stray_q;
endmodule

// File: tb/tb_network_requester.sv
// Directed bench for network_requester: posted write, stalled read with reply,
// timeout, reply-vs-timeout race, misaddressed reply, stray saturation, resets.
module tb_network_requester;
  localparam int NAW  = 4;
  localparam int CBAW = 8;
  localparam int DW   = 32;
  localparam int TO   = 64;

  logic           clk;
  logic           reset;
  logic [NAW-1:0] local_addr;
  logic [7:0]     stray_count;
  int             n_checks;
  int             n_fail;
  logic           early;

  network_requester_if #(.NAW(NAW), .CBAW(CBAW), .DW(DW)) bus ();

  network_requester #(
    .NETWORK_ADDRESS_WIDTH   (NAW),
    .CACHE_BANK_ADDRESS_WIDTH(CBAW),
    .DATA_WIDTH              (DW),
    .TIMEOUT_CYCLES          (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .localRouterAddress(local_addr),
    .strayCount        (stray_count),
    .bus               (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt_in(input logic rd, input logic wr, input logic [NAW-1:0] router,
                            input logic [DW-1:0] data);
    bus.readIn               = rd;
    bus.writeIn              = wr;
    bus.destinationAddressIn = {router, 8'h55};
    bus.requesterAddressIn   = 4'd9;
    bus.dataIn               = data;
  endtask

  task automatic request(input logic wr, input logic [NAW+CBAW-1:0] addr, input logic [DW-1:0] data);
    bus.reqValid   = 1'b1;
    bus.reqWrite   = wr;
    bus.reqAddress = addr;
    bus.reqData    = data;
    tick();
    bus.reqValid   = 1'b0;
  endtask

  function automatic logic [63:0] pkt_out();
    return {bus.destinationAddressOut, bus.requesterAddressOut, bus.readOut, bus.writeOut, bus.dataOut};
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    local_addr     = 4'd4;
    bus.portEnable = 1'b0;
    bus.reqValid   = 1'b0;
    bus.reqWrite   = 1'b0;
    bus.reqAddress = '0;
    bus.reqData    = '0;
    set_pkt_in(1'b0, 1'b0, 4'd0, 32'h0);
    #3;
    check("por_ready", bus.reqReady, 1);
    check("por_resp", {bus.respValid, bus.respData, bus.respError}, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Reset mid-run: build up strays, park in SEND, then drop reset between edges.
    set_pkt_in(1'b1, 1'b1, 4'd4, 32'h11);
    repeat (2) tick();
    set_pkt_in(1'b0, 1'b0, 4'd0, 32'h0);
    check("stray_two", stray_count, 2);
    request(1'b0, {4'd3, 8'h20}, 32'h0);
    check("send_not_ready", bus.reqReady, 0);
    #2 reset = 1'b0;
    #1;
    check("async_ready", bus.reqReady, 1);
    check("async_stray", stray_count, 0);
    check("async_pkt", pkt_out(), 0);
    check("async_resp", {bus.respValid, bus.respError}, 0);
    tick();
    reset = 1'b1;
    tick();

    // Posted write with the port open.
    bus.portEnable = 1'b1;
    request(1'b1, {4'd2, 8'h10}, 32'hA5);
    check("wr_ready_drop", bus.reqReady, 0);
    check("wr_no_pkt_yet", pkt_out(), 0);
    tick();
    check("wr_dest", bus.destinationAddressOut, 12'h210);
    check("wr_requester", bus.requesterAddressOut, 4);
    check("wr_flags", {bus.readOut, bus.writeOut}, 2'b01);
    check("wr_data", bus.dataOut, 32'hA5);
    check("wr_ready_back", bus.reqReady, 1);
    tick();
    check("wr_pkt_gone", pkt_out(), 0);
    check("wr_no_resp", bus.respValid, 0);

    // Read stalled 5 cycles on a closed port, then replied to 3 cycles after launch.
    bus.portEnable = 1'b0;
    request(1'b0, {4'd8, 8'h03}, 32'h1234);
    early = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pkt_out() != 0) early = 1'b1;
    end
    check("rd_stall_quiet", early, 0);
    bus.portEnable = 1'b1;
    tick();
    check("rd_dest", bus.destinationAddressOut, 12'h803);
    check("rd_flags", {bus.readOut, bus.writeOut}, 2'b10);
    check("rd_data_zero", bus.dataOut, 0);
    tick();
    check("rd_pkt_gone", pkt_out(), 0);
    check("rd_wait_busy", {bus.reqReady, bus.respValid}, 0);
    tick();
    set_pkt_in(1'b1, 1'b1, 4'd4, 32'hDEAD);
    tick();
    set_pkt_in(1'b0, 1'b0, 4'd0, 32'h0);
    check("rd_resp", {bus.respValid, bus.respError, bus.respData}, {2'b10, 32'hDEAD});
    check("rd_ready", bus.reqReady, 1);
    tick();
    check("rd_pulse_end", bus.respValid, 0);
    check("rd_no_stray", stray_count, 0);

    // Timeout: response exactly TO edges after the launch edge.
    request(1'b0, {4'd7, 8'h01}, 32'h0);
    tick();
    check("to_launch", bus.readOut, 1);
    early = 1'b0;
    for (int j = 1; j < TO; j++) begin
      tick();
      if (bus.respValid) early = 1'b1;
    end
    check("to_not_early", early, 0);
    tick();
    check("to_resp", {bus.respValid, bus.respError, bus.respData}, {2'b11, 32'h0});
    check("to_ready", bus.reqReady, 1);
    tick();
    check("to_pulse_end", bus.respValid, 0);

    // Reply on the same edge as the timeout: the reply wins.
    request(1'b0, {4'd7, 8'h02}, 32'h0);
    tick();
    for (int j = 1; j < TO; j++) tick();
    set_pkt_in(1'b1, 1'b1, 4'd4, 32'hBEEF);
    tick();
    set_pkt_in(1'b0, 1'b0, 4'd0, 32'h0);
    check("race_resp", {bus.respValid, bus.respError, bus.respData}, {2'b10, 32'hBEEF});

    // A reply for router 5 is not ours and the read times out.
    tick();
    request(1'b0, {4'd6, 8'h04}, 32'h0);
    tick();
    set_pkt_in(1'b1, 1'b1, 4'd5, 32'hCAFE);
    early = 1'b0;
    for (int j = 1; j < TO; j++) begin
      tick();
      if (j == 10) set_pkt_in(1'b0, 1'b0, 4'd0, 32'h0);
      if (bus.respValid) early = 1'b1;
    end
    check("misaddr_ignored", early, 0);
    tick();
    check("misaddr_timeout", {bus.respValid, bus.respError, bus.respData}, {2'b11, 32'h0});
    check("misaddr_no_stray", stray_count, 0);

    // Stray saturation while idle; a non-reply packet must not count.
    tick();
    set_pkt_in(1'b1, 1'b0, 4'd4, 32'h0);
    repeat (3) tick();
    check("nonreply_ignored", stray_count, 0);
    set_pkt_in(1'b1, 1'b1, 4'd4, 32'h77);
    repeat (254) tick();
    check("stray_254", stray_count, 8'hFE);
    repeat (46) tick();
    set_pkt_in(1'b0, 1'b0, 4'd0, 32'h0);
    check("stray_sat", stray_count, 8'hFF);

    // Reset during WAIT abandons the read; the late reply is a stray.
    request(1'b0, {4'd1, 8'h09}, 32'h0);
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    check("wait_reset_stray", stray_count, 0);
    tick();
    reset = 1'b1;
    set_pkt_in(1'b1, 1'b1, 4'd4, 32'h99);
    tick();
    set_pkt_in(1'b0, 1'b0, 4'd0, 32'h0);
    check("late_reply_stray", stray_count, 1);
    check("late_reply_no_resp", bus.respValid, 0);
    tick();
    check("late_reply_no_resp2", bus.respValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
